stk_pipe_wrbk: RTL and testbench

Writeback (WRBK) stage of the stack pipeline; consumes the registered MEM->WRBK update (engine id, opcode, next head/tail pointers, popped data) and commits it to the per-engine architectural context (head, tail, occupancy).
Issues the per-engine response (valid, data, error) one cycle later.
Returns freed line pointers to the allocator through a small dealloc queue, and back-pressures admission when that queue nears full.
Exported context feeds LK; the wrbk_uc_* forward path is unchanged.

---
 rtl/stk_pkg.sv | 39 +++
 rtl/stk_pipe_wrbk_dq.sv | 58 +++++
 rtl/stk_pipe_wrbk.sv | 166 ++++++++++++++++
 tb/tb_stk_pipe_wrbk.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stk_pkg.sv
// Shared types for the stack pipeline: opcodes, pointer/count widths,
// the per-engine context record and the dealloc queue depth.
package stk_pkg;
  localparam int ENGS_N = 4;
  localparam int PTR_W  = 8;
  localparam int DQ_N   = 4;
  localparam int DQ_AW  = $clog2(DQ_N);
  localparam int ENG_W  = $clog2(ENGS_N);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DAT_W  = 128;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [ENG_W-1:0] engid_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEPTH_MAX = cnt_t'(2 ** PTR_W);

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_INV  = 2'd3
  } opcode_t;

  typedef struct packed {
    logic head_vld;
    ptr_t head_ptr;
    logic tail_vld;
    ptr_t tail_ptr;
    cnt_t cnt;
  } ctx_t;

  function automatic logic [ENGS_N-1:0] onehot(input engid_t e);
    logic [ENGS_N-1:0] r;
    r    = '0;
    r[e] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/stk_pipe_wrbk_dq.sv
// Dealloc FIFO returning freed line pointers to the allocator; tracks
// overflow (sticky) and raises admission stall near full.
module stk_pipe_wrbk_dq
  import stk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enq_i,
  input  ptr_t enq_ptr_i,
  input  logic deq_rdy_i,
  output logic vld_o,
  output ptr_t ptr_o,
  output logic stall_o,
  output logic ovf_o
);
  typedef logic [DQ_AW:0] qp_t;

  ptr_t mem_q [DQ_N];
  qp_t  wr_q, wr_d, rd_q, rd_d, occ_d;
  logic stall_q, ovf_q;
  logic empty, full, deq, enq_ok;

  assign empty  = wr_q == rd_q;
  assign full   = (wr_q[DQ_AW] != rd_q[DQ_AW]) &&
                  (wr_q[DQ_AW-1:0] == rd_q[DQ_AW-1:0]);
  assign deq    = !empty && deq_rdy_i;
  // A same-cycle dequeue frees the slot, so enqueue at full is legal then.
  assign enq_ok = enq_i && (!full || deq);

  always_comb begin
    wr_d  = wr_q + qp_t'(enq_ok);
    rd_d  = rd_q + qp_t'(deq);
    occ_d = wr_d - rd_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      stall_q <= occ_d >= qp_t'(DQ_N - 2);
      if (enq_i && !enq_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[wr_q[DQ_AW-1:0]] <= enq_ptr_i;
  end

  assign vld_o   = !empty;
  assign ptr_o   = mem_q[rd_q[DQ_AW-1:0]];
  assign stall_o = stall_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/stk_pipe_wrbk.sv
// Writeback stage: commits MEM updates to per-engine context and responds.
// Optional per-engine counters under STK_PIPE_WRBK_STATS_EN.
module stk_pipe_wrbk
  import stk_pkg::*;
(
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     i_wrbk_uc_vld_r,
  input  engid_t                   i_wrbk_uc_engid_r,
  input  opcode_t                  i_wrbk_uc_opcode_r,
  input  logic                     i_wrbk_uc_head_vld_r,
  input  ptr_t                     i_wrbk_uc_head_ptr_r,
  input  logic                     i_wrbk_uc_tail_vld_r,
  input  ptr_t                     i_wrbk_uc_tail_ptr_r,
  input  logic [DAT_W-1:0]         i_wrbk_dat_r,
  output logic [ENGS_N-1:0]        o_ctx_head_vld_r,
  output logic [ENGS_N*PTR_W-1:0]  o_ctx_head_ptr_r,
  output logic [ENGS_N-1:0]        o_ctx_tail_vld_r,
  output logic [ENGS_N*PTR_W-1:0]  o_ctx_tail_ptr_r,
  output logic [ENGS_N-1:0]        o_ctx_empty_r,
  output logic [ENGS_N-1:0]        o_rsp_vld,
  output logic                     o_rsp_err,
  output logic [DAT_W-1:0]         o_rsp_dat,
  output logic                     o_dealloc_vld,
  output ptr_t                     o_dealloc_ptr,
  input  logic                     i_dealloc_rdy,
  output logic                     o_ad_stall_r,
  output logic                     o_dq_ovf_r
`ifdef STK_PIPE_WRBK_STATS_EN
  ,
  output logic [ENGS_N*32-1:0]     o_stat_push,
  output logic [ENGS_N*32-1:0]     o_stat_pop,
  output logic [ENGS_N*32-1:0]     o_stat_err
`endif
);
  ctx_t              ctx_q [ENGS_N];
  ctx_t              ctx_d [ENGS_N];
  ctx_t              cur;
  logic [ENGS_N-1:0] rsp_vld_q, rsp_vld_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DAT_W-1:0]  rsp_dat_q, rsp_dat_d;
  logic              enq, push_ok, pop_ok, err;
  ptr_t              enq_ptr;
  engid_t            eng;

  // Tail is derived locally from head on first push and on drain.
  logic unused_tail;
  assign unused_tail = ^{i_wrbk_uc_tail_vld_r, i_wrbk_uc_tail_ptr_r};

  assign eng = i_wrbk_uc_engid_r;

  always_comb begin
    ctx_d     = ctx_q;
    cur       = ctx_q[eng];
    rsp_vld_d = '0;
    rsp_err_d = 1'b0;
    rsp_dat_d = '0;
    enq       = 1'b0;
    enq_ptr   = ctx_q[eng].head_ptr;
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    err       = 1'b0;
    if (i_wrbk_uc_vld_r && i_wrbk_uc_opcode_r != OP_NOP) begin
      rsp_vld_d = onehot(eng);
      case (i_wrbk_uc_opcode_r)
        OP_PUSH: begin
          if (cur.cnt == DEPTH_MAX) begin
            err = 1'b1;
          end else begin
            push_ok      = 1'b1;
            cur.head_ptr = i_wrbk_uc_head_ptr_r;
            cur.head_vld = 1'b1;
            if (cur.cnt == cnt_t'(0)) begin
              cur.tail_ptr = i_wrbk_uc_head_ptr_r;
              cur.tail_vld = 1'b1;
            end
            cur.cnt = cur.cnt + cnt_t'(1);
          end
        end
        OP_POP: begin
          if (cur.cnt == cnt_t'(0)) begin
            err = 1'b1;
          end else begin
            pop_ok       = 1'b1;
            enq          = 1'b1;
            rsp_dat_d    = i_wrbk_dat_r;
            cur.head_ptr = i_wrbk_uc_head_ptr_r;
            cur.head_vld = i_wrbk_uc_head_vld_r;
            if (cur.cnt == cnt_t'(1)) begin
              cur.head_vld = 1'b0;
              cur.tail_vld = 1'b0;
            end
            cur.cnt = cur.cnt - cnt_t'(1);
          end
        end
        default: err = 1'b1;
      endcase
      rsp_err_d  = err;
      ctx_d[eng] = cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < ENGS_N; i++) ctx_q[i] <= '0;
      rsp_vld_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      ctx_q     <= ctx_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_err_q <= rsp_err_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  for (genvar g = 0; g < ENGS_N; g++) begin : g_ctx
    assign o_ctx_head_vld_r[g]              = ctx_q[g].head_vld;
    assign o_ctx_head_ptr_r[g*PTR_W +: PTR_W] = ctx_q[g].head_ptr;
    assign o_ctx_tail_vld_r[g]              = ctx_q[g].tail_vld;
    assign o_ctx_tail_ptr_r[g*PTR_W +: PTR_W] = ctx_q[g].tail_ptr;
    assign o_ctx_empty_r[g]                 = ctx_q[g].cnt == cnt_t'(0);
  end

  assign o_rsp_vld = rsp_vld_q;
  assign o_rsp_err = rsp_err_q;
  assign o_rsp_dat = rsp_dat_q;

  stk_pipe_wrbk_dq u_dq (
    .clk       (clk),
    .rst_n     (arst_n),
    .enq_i     (enq),
    .enq_ptr_i (enq_ptr),
    .deq_rdy_i (i_dealloc_rdy),
    .vld_o     (o_dealloc_vld),
    .ptr_o     (o_dealloc_ptr),
    .stall_o   (o_ad_stall_r),
    .ovf_o     (o_dq_ovf_r)
  );

`ifdef STK_PIPE_WRBK_STATS_EN
  logic [31:0] st_push_q [ENGS_N];
  logic [31:0] st_pop_q  [ENGS_N];
  logic [31:0] st_err_q  [ENGS_N];

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < ENGS_N; i++) begin
        st_push_q[i] <= '0;
        st_pop_q[i]  <= '0;
        st_err_q[i]  <= '0;
      end
    end else begin
      if (push_ok && st_push_q[eng] != '1) st_push_q[eng] <= st_push_q[eng] + 32'd1;
      if (pop_ok && st_pop_q[eng] != '1) st_pop_q[eng] <= st_pop_q[eng] + 32'd1;
      if (err && st_err_q[eng] != '1) st_err_q[eng] <= st_err_q[eng] + 32'd1;
    end
  end

  for (genvar g = 0; g < ENGS_N; g++) begin : g_st
    assign o_stat_push[g*32 +: 32] = st_push_q[g];
    assign o_stat_pop[g*32 +: 32]  = st_pop_q[g];
    assign o_stat_err[g*32 +: 32]  = st_err_q[g];
  end
`endif
endmodule

// File: tb/tb_stk_pipe_wrbk.sv
// Bench for stk_pipe_wrbk: vector table, stack model, dealloc scoreboard.
// Build with STK_PIPE_WRBK_STATS_EN to hook up the optional counters.
module tb_stk_pipe_wrbk;
  import stk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    arst_n;
  logic                    i_vld;
  engid_t                  i_eng;
  opcode_t                 i_op;
  logic                    i_hvld, i_tvld;
  ptr_t                    i_hptr, i_tptr;
  logic [DAT_W-1:0]        i_dat;
  logic [ENGS_N-1:0]       hvld_o, tvld_o, empty_o, rsp_vld;
  logic [ENGS_N*PTR_W-1:0] hptr_o, tptr_o;
  logic                    rsp_err;
  logic [DAT_W-1:0]        rsp_dat;
  logic                    dq_vld, dq_rdy, stall, ovf;
  ptr_t                    dq_ptr;
`ifdef STK_PIPE_WRBK_STATS_EN
  logic [ENGS_N*32-1:0]    st_push, st_pop, st_err;
`endif

  stk_pipe_wrbk dut (
    .clk                  (clk),
    .arst_n               (arst_n),
    .i_wrbk_uc_vld_r      (i_vld),
    .i_wrbk_uc_engid_r    (i_eng),
    .i_wrbk_uc_opcode_r   (i_op),
    .i_wrbk_uc_head_vld_r (i_hvld),
    .i_wrbk_uc_head_ptr_r (i_hptr),
    .i_wrbk_uc_tail_vld_r (i_tvld),
    .i_wrbk_uc_tail_ptr_r (i_tptr),
    .i_wrbk_dat_r         (i_dat),
    .o_ctx_head_vld_r     (hvld_o),
    .o_ctx_head_ptr_r     (hptr_o),
    .o_ctx_tail_vld_r     (tvld_o),
    .o_ctx_tail_ptr_r     (tptr_o),
    .o_ctx_empty_r        (empty_o),
    .o_rsp_vld            (rsp_vld),
    .o_rsp_err            (rsp_err),
    .o_rsp_dat            (rsp_dat),
    .o_dealloc_vld        (dq_vld),
    .o_dealloc_ptr        (dq_ptr),
    .i_dealloc_rdy        (dq_rdy),
    .o_ad_stall_r         (stall),
    .o_dq_ovf_r           (ovf)
`ifdef STK_PIPE_WRBK_STATS_EN
    ,
    .o_stat_push          (st_push),
    .o_stat_pop           (st_pop),
    .o_stat_err           (st_err)
`endif
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_drained = 0;
  ptr_t sb_q [$];
  ptr_t stk [ENGS_N][$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ptr_t hp(input int e);
    return hptr_o[e*PTR_W +: PTR_W];
  endfunction

  function automatic ptr_t tp(input int e);
    return tptr_o[e*PTR_W +: PTR_W];
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Dealloc scoreboard: every accepted pointer must match the oldest expected one.
  always begin
    @(negedge clk);
    #2;
    if (arst_n && dq_vld && dq_rdy) begin
      n_tests++;
      n_drained++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL dealloc_unexpected: got ptr %0h expected none", dq_ptr);
      end else begin
        n_tests--;
        chk("dealloc_ptr", dq_ptr, sb_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns one negedge later with the result visible.
  task automatic op(input int e, input opcode_t o, input ptr_t h, input logic hv,
                    input logic [127:0] d, input logic enq, input ptr_t eptr);
    i_vld  = 1'b1;
    i_eng  = engid_t'(e);
    i_op   = o;
    i_hptr = h;
    i_hvld = hv;
    i_tptr = ~h;
    i_tvld = hv;
    i_dat  = d;
    if (enq) sb_q.push_back(eptr);
    @(negedge clk);
    i_vld = 1'b0;
    i_op  = OP_NOP;
  endtask

  task automatic push_m(input int e, input ptr_t p);
    logic full;
    full = stk[e].size() == 256;
    op(e, OP_PUSH, p, 1'b1, rnd(), 1'b0, '0);
    chk("push_rsp_vld", rsp_vld, 128'(1 << e));
    chk("push_err", rsp_err, full);
    if (!full) stk[e].push_back(p);
    chk("push_head", hp(e), stk[e][$]);
  endtask

  task automatic pop_m(input int e, input logic enq);
    logic [127:0] d;
    ptr_t old, nxt;
    logic hv;
    d = rnd();
    if (stk[e].size() == 0) begin
      op(e, OP_POP, 8'h5A, 1'b1, d, 1'b0, '0);
      chk("pop_empty_err", rsp_err, 1'b1);
      chk("pop_empty_dat", rsp_dat, '0);
      chk("pop_empty_empty", empty_o[e], 1'b1);
    end else begin
      old = stk[e].pop_back();
      hv  = stk[e].size() != 0;
      nxt = hv ? stk[e][$] : '0;
      op(e, OP_POP, nxt, hv, d, enq, old);
      chk("pop_err", rsp_err, 1'b0);
      chk("pop_dat", rsp_dat, d);
      chk("pop_head_vld", hvld_o[e], hv);
      chk("pop_empty", empty_o[e], !hv);
      if (hv) chk("pop_head", hp(e), nxt);
      else chk("pop_tail_vld", tvld_o[e], 1'b0);
    end
    chk("pop_rsp_vld", rsp_vld, 128'(1 << e));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_head_vld"}, hvld_o, '0);
    chk({tag, "_head_ptr"}, hptr_o, '0);
    chk({tag, "_tail_vld"}, tvld_o, '0);
    chk({tag, "_tail_ptr"}, tptr_o, '0);
    chk({tag, "_empty"}, empty_o, {ENGS_N{1'b1}});
    chk({tag, "_rsp_vld"}, rsp_vld, '0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_rsp_dat"}, rsp_dat, '0);
    chk({tag, "_dq_vld"}, dq_vld, 1'b0);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
  endtask

  typedef struct {
    int               eng;
    opcode_t          op;
    ptr_t             hptr_in;
    logic             hvld_in;
    logic [127:0]     dat;
    logic [ENGS_N-1:0] rsp;
    logic             err;
    logic [127:0]     rdat;
    logic             hvld;
    ptr_t             hptr;
    logic             tvld;
    ptr_t             tptr;
    logic             emp;
    logic             enq;
    ptr_t             eptr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [127:0] ab, cd;
    bit done;
    ab = {16{8'hAB}};
    cd = {16{8'hCD}};
    tbl[0] = '{0, OP_PUSH, 8'h05, 1'b1, '0, 4'b0001, 1'b0, '0, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1, OP_PUSH, 8'h10, 1'b1, '0, 4'b0010, 1'b0, '0, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1, OP_PUSH, 8'h11, 1'b1, '0, 4'b0010, 1'b0, '0, 1'b1, 8'h11, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1, OP_POP,  8'h10, 1'b1, ab, 4'b0010, 1'b0, ab, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 1'b1, 8'h11};
    tbl[4] = '{2, OP_POP,  8'h33, 1'b1, cd, 4'b0100, 1'b1, '0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{0, OP_INV,  8'h77, 1'b1, cd, 4'b0001, 1'b1, '0, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{0, OP_NOP,  8'h77, 1'b1, cd, 4'b0000, 1'b0, '0, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{0, OP_POP,  8'h00, 1'b0, 128'h1234, 4'b0001, 1'b0, 128'h1234, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 8'h05};

    arst_n = 1'b0;
    i_vld  = 1'b0;
    i_eng  = '0;
    i_op   = OP_NOP;
    i_hvld = 1'b0;
    i_hptr = '0;
    i_tvld = 1'b0;
    i_tptr = '0;
    i_dat  = '0;
    dq_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    arst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[k]) begin
      op(tbl[k].eng, tbl[k].op, tbl[k].hptr_in, tbl[k].hvld_in, tbl[k].dat,
         tbl[k].enq, tbl[k].eptr);
      chk($sformatf("v%0d_rsp_vld", k), rsp_vld, tbl[k].rsp);
      chk($sformatf("v%0d_err", k), rsp_err, tbl[k].err);
      chk($sformatf("v%0d_dat", k), rsp_dat, tbl[k].rdat);
      chk($sformatf("v%0d_head_vld", k), hvld_o[tbl[k].eng], tbl[k].hvld);
      chk($sformatf("v%0d_tail_vld", k), tvld_o[tbl[k].eng], tbl[k].tvld);
      chk($sformatf("v%0d_tail_ptr", k), tp(tbl[k].eng), tbl[k].tptr);
      chk($sformatf("v%0d_empty", k), empty_o[tbl[k].eng], tbl[k].emp);
      if (tbl[k].hvld) chk($sformatf("v%0d_head_ptr", k), hp(tbl[k].eng), tbl[k].hptr);
    end
    stk[1].push_back(8'h10);
    repeat (2) @(negedge clk);

    // Back-pressure: allocator stalled, queue fills then overflows.
    dq_rdy = 1'b0;
    for (int i = 0; i < 6; i++) push_m(2, ptr_t'(8'h20 + i));
    pop_m(2, 1'b1);
    chk("stall_after_1", stall, 1'b0);
    pop_m(2, 1'b1);
    chk("stall_after_2", stall, 1'b1);
    pop_m(2, 1'b1);
    pop_m(2, 1'b1);
    chk("ovf_at_full", ovf, 1'b0);
    chk("stall_at_full", stall, 1'b1);
    pop_m(2, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    chk("dq_head_vld", dq_vld, 1'b1);
    chk("dq_head_ptr", dq_ptr, 8'h25);
    n_drained = 0;
    dq_rdy = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (!dq_vld) done = 1'b1;
    end
    chk("drain_done", done, 1'b1);
    chk("drain_count", n_drained, 4);
    chk("stall_after_drain", stall, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);

    // Depth limit on eng3.
    for (int i = 0; i < 256; i++) push_m(3, ptr_t'(i));
    chk("full_tail", tp(3), 8'h00);
    push_m(3, 8'hAA);
    for (int i = 0; i < 256; i++) pop_m(3, 1'b1);
    chk("drained_tail_vld", tvld_o[3], 1'b0);
    pop_m(3, 1'b1);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    // Reset while the queue holds pointers and ovf is set.
    dq_rdy = 1'b0;
    push_m(0, 8'h40);
    push_m(0, 8'h41);
    pop_m(0, 1'b1);
    pop_m(0, 1'b1);
    chk("pre_reset_dq_vld", dq_vld, 1'b1);
    chk("pre_reset_stall", stall, 1'b1);
    arst_n = 1'b0;
    op(1, OP_PUSH, 8'h99, 1'b1, rnd(), 1'b0, '0);
    chk_reset("midrst");
    sb_q.delete();
    for (int e = 0; e < ENGS_N; e++) stk[e].delete();
    arst_n = 1'b1;
    dq_rdy = 1'b1;
    push_m(1, 8'h66);
    chk("post_reset_tail", tp(1), 8'h66);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
